// File: rtl/tqvp_hx2003_pulse_pkg.sv
// Shared definitions for the pulse sequencer: playback states, default widths
// and the bit layout of a {level, duration} descriptor.
package tqvp_hx2003_pulse_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_DUR_W = 15;
  localparam int DEFAULT_PRE_W = 8;

  // Descriptor layout at the default duration width: level on top, duration below
  localparam int LEVEL_BIT = DEFAULT_DUR_W;
  localparam int DUR_MSB   = DEFAULT_DUR_W - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/tqvp_hx2003_pulse_fifo.sv
// Descriptor FIFO with registered count/full/empty and a flush that wins over push/pop.
// The head entry is presented combinationally so the sequencer can load it on the pop edge.
module tqvp_hx2003_pulse_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/tqvp_hx2003_pulse_sequencer.sv
// Plays queued {level, duration} descriptors out as a gating envelope for the
// carrier stage; each entry lasts (D+1)(P+1) clocks and entries chain without gaps.
module tqvp_hx2003_pulse_sequencer
  import tqvp_hx2003_pulse_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DUR_W = DEFAULT_DUR_W,
  parameter int PRE_W = DEFAULT_PRE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DUR_W:0]         wr_data,
  input  logic [PRE_W-1:0]       prescale,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clr_ovf,
  output logic                   pulse_level,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [DUR_W:0]   head;
  logic [DUR_W-1:0] dur_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic             level_r;
  logic             tick;
  logic             entry_end;
  logic             push;
  logic             pop;
  logic             load;
  logic             finish;
  logic             ovf_evt;

  assign tick      = (pre_cnt == '0);
  assign entry_end = (state == RUN) && tick && (dur_cnt == '0);
  assign push      = wr_en && !full && !stop;
  assign ovf_evt   = wr_en && full && !stop;

  tqvp_hx2003_pulse_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DUR_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (stop),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stop overrides everything; an entry end either chains the next entry or finishes
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !empty) begin
            pop       = 1'b1;
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (entry_end) begin
            if (!empty) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              finish    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r  <= 1'b0;
      dur_cnt  <= '0;
      pre_cnt  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= finish;
      if (stop || finish) begin
        level_r <= 1'b0;
        dur_cnt <= '0;
        pre_cnt <= '0;
      end else if (load) begin
        level_r <= head[DUR_W];
        dur_cnt <= head[DUR_W-1:0];
        pre_cnt <= prescale;
      end else if (state == RUN) begin
        if (tick) begin
          pre_cnt <= prescale;
          dur_cnt <= dur_cnt - DUR_W'(1);
        end else begin
          pre_cnt <= pre_cnt - PRE_W'(1);
        end
      end
      // A simultaneous overflow beats the clear so the event is never lost
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign pulse_level = level_r;
  assign busy        = (state == RUN);

endmodule
